// File: rtl/bf2_pair_feeder.sv
// Input feeder for the radix-2 butterfly: buffers the first half-frame, then pairs x[k] with x[k+HALF].
// Optional BF2_FEEDER_FRAME_TAG_EN adds pair_idx / frame_last outputs.
module bf2_pair_feeder #(
  parameter int unsigned WIDTH = 13,
  parameter int unsigned DEPTH = 2,
  parameter int unsigned HALF  = 4
) (
  input  logic                            clk,
  input  logic                            rstn,
  input  logic                            flush,
  input  logic                            in_valid,
  input  logic signed [DEPTH*WIDTH-1:0]   din_R,
  input  logic signed [DEPTH*WIDTH-1:0]   din_Q,
  output logic                            pair_valid,
  output logic signed [DEPTH*WIDTH-1:0]   dout_R_1,
  output logic signed [DEPTH*WIDTH-1:0]   dout_Q_1,
  output logic signed [DEPTH*WIDTH-1:0]   dout_R_2,
  output logic signed [DEPTH*WIDTH-1:0]   dout_Q_2,
  output logic                            busy
`ifdef BF2_FEEDER_FRAME_TAG_EN
  ,
  output logic        [$clog2(HALF)-1:0]  pair_idx,
  output logic                            frame_last
`endif
);

  localparam int unsigned CW = $clog2(HALF);
  localparam int unsigned BW = DEPTH * WIDTH;

  typedef enum logic {StFill, StPair} state_e;

  state_e          state_q;
  logic [CW-1:0]   cnt_q;
  logic [BW-1:0]   mem_r [HALF];
  logic [BW-1:0]   mem_i [HALF];
  logic            accept;
  logic            cnt_last;

  assign accept   = in_valid & ~flush;
  assign cnt_last = (cnt_q == CW'(HALF - 1));

  // First-half storage; no reset, stale entries are always rewritten before being read.
  always_ff @(posedge clk) begin
    if (state_q == StFill && accept) begin
      mem_r[cnt_q] <= din_R;
      mem_i[cnt_q] <= din_Q;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= StFill;
      cnt_q      <= '0;
      busy       <= 1'b0;
      pair_valid <= 1'b0;
      dout_R_1   <= '0;
      dout_Q_1   <= '0;
      dout_R_2   <= '0;
      dout_Q_2   <= '0;
`ifdef BF2_FEEDER_FRAME_TAG_EN
      pair_idx   <= '0;
      frame_last <= 1'b0;
`endif
    end else begin
      // Outputs are zero on every cycle without an accepted PAIR beat.
      pair_valid <= 1'b0;
      dout_R_1   <= '0;
      dout_Q_1   <= '0;
      dout_R_2   <= '0;
      dout_Q_2   <= '0;
`ifdef BF2_FEEDER_FRAME_TAG_EN
      pair_idx   <= '0;
      frame_last <= 1'b0;
`endif
      if (flush) begin
        state_q <= StFill;
        cnt_q   <= '0;
        busy    <= 1'b0;
      end else if (accept) begin
        cnt_q <= cnt_last ? '0 : cnt_q + CW'(1);
        unique case (state_q)
          StFill: begin
            if (cnt_last) begin
              state_q <= StPair;
              busy    <= 1'b1;
            end
          end
          StPair: begin
            pair_valid <= 1'b1;
            dout_R_1   <= mem_r[cnt_q];
            dout_Q_1   <= mem_i[cnt_q];
            dout_R_2   <= din_R;
            dout_Q_2   <= din_Q;
`ifdef BF2_FEEDER_FRAME_TAG_EN
            pair_idx   <= cnt_q;
            frame_last <= cnt_last;
`endif
            if (cnt_last) begin
              state_q <= StFill;
              busy    <= 1'b0;
            end
          end
          default: state_q <= StFill;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_bf2_pair_feeder.sv
// Directed bench for bf2_pair_feeder (WIDTH=13, DEPTH=2, HALF=4); beat value v drives
// din_R={v,-v}, din_Q={100+v,-100-v}. Expected pairs are recorded per beat and matched later.
module tb_bf2_pair_feeder;

  localparam int W  = 13;
  localparam int BW = 2 * W;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic [BW-1:0] din_R = '0;
  logic [BW-1:0] din_Q = '0;
  logic          pair_valid;
  logic [BW-1:0] dout_R_1, dout_Q_1, dout_R_2, dout_Q_2;
  logic          busy;
`ifdef BF2_FEEDER_FRAME_TAG_EN
  logic [1:0]    pair_idx;
  logic          frame_last;
`endif

  bf2_pair_feeder #(.WIDTH(W), .DEPTH(2), .HALF(4)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .flush      (flush),
    .in_valid   (in_valid),
    .din_R      (din_R),
    .din_Q      (din_Q),
    .pair_valid (pair_valid),
    .dout_R_1   (dout_R_1),
    .dout_Q_1   (dout_Q_1),
    .dout_R_2   (dout_R_2),
    .dout_Q_2   (dout_Q_2),
    .busy       (busy)
`ifdef BF2_FEEDER_FRAME_TAG_EN
    ,
    .pair_idx   (pair_idx),
    .frame_last (frame_last)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {int cyc; logic [BW-1:0] r1, q1, r2, q2; logic [1:0] idx; logic last;} pair_t;
  typedef struct {int cyc; int v; int k;} exp_t;

  pair_t pq[$];
  exp_t  eq[$];
  int    n_cmp = 0;
  int    n_err = 0;
  int    cyc_p = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [BW-1:0] mk_r(input int v);
    logic [W-1:0] a, b;
    a = W'(v);
    b = W'(-v);
    return {a, b};
  endfunction

  function automatic logic [BW-1:0] mk_q(input int v);
    logic [W-1:0] a, b;
    a = W'(100 + v);
    b = W'(-100 - v);
    return {a, b};
  endfunction

  always @(posedge clk) cyc_p++;

  // Collect emitted pairs; every non-pair cycle must show all-zero data.
  always @(negedge clk) begin
    pair_t p;
    if (pair_valid) begin
      p.cyc = cyc_p;
      p.r1 = dout_R_1; p.q1 = dout_Q_1; p.r2 = dout_R_2; p.q2 = dout_Q_2;
      p.idx = '0; p.last = 1'b0;
`ifdef BF2_FEEDER_FRAME_TAG_EN
      p.idx = pair_idx; p.last = frame_last;
`endif
      pq.push_back(p);
    end else begin
`ifdef BF2_FEEDER_FRAME_TAG_EN
      check("idle_tag", {pair_idx, frame_last}, 0);
`endif
      check("idle_zero", {dout_R_1, dout_Q_1, dout_R_2, dout_Q_2}, 0);
    end
  end

  // Set inputs at a falling edge; e is the index of the rising edge that samples them.
  task automatic drive(input logic v, input logic f, input int val, output int e);
    @(negedge clk);
    in_valid = v;
    flush    = f;
    din_R    = mk_r(val);
    din_Q    = mk_q(val);
    e        = cyc_p + 1;
  endtask

  task automatic idle(input int n);
    int e;
    repeat (n) drive(1'b0, 1'b0, 0, e);
  endtask

  // One 8-beat frame; cut >= 0 ends it at that beat with a flush (or async reset if cut_rst).
  task automatic frame(input int base, input int gap, input int cut, input logic cut_rst);
    int e;
    for (int b = 0; b < 8; b++) begin
      if (b == cut) begin
        if (cut_rst) begin
          @(negedge clk);
          #2;
          rstn     = 1'b0;
          in_valid = 1'b0;
          #1;
          check("rst_async", {pair_valid, busy, dout_R_1, dout_Q_1, dout_R_2, dout_Q_2}, 0);
        end else begin
          drive(1'b1, 1'b1, base + b, e);
        end
        return;
      end
      drive(1'b1, 1'b0, base + b, e);
      if (b == 0) check("busy_fill", busy, 0);
      if (b == 4) check("busy_pair", busy, 1);
      if (b >= 4) eq.push_back('{e, base + b - 4, b - 4});
      if (gap > 0 && (b == 2 || b == 5)) idle(gap);
    end
  endtask

  task automatic drain(input string tag, input int n);
    int v;
    check({tag, "_count"}, pq.size(), n);
    for (int i = 0; i < eq.size() && i < pq.size(); i++) begin
      v = eq[i].v;
      check({tag, "_cyc"}, pq[i].cyc, eq[i].cyc);
      check({tag, "_data"}, {pq[i].r1, pq[i].q1, pq[i].r2, pq[i].q2},
            {mk_r(v), mk_q(v), mk_r(v + 4), mk_q(v + 4)});
`ifdef BF2_FEEDER_FRAME_TAG_EN
      check({tag, "_idx"}, pq[i].idx, eq[i].k);
      check({tag, "_last"}, pq[i].last, (eq[i].k == 3));
`endif
    end
    pq.delete();
    eq.delete();
  endtask

  initial begin
    int gap12;
    // Reset held, then released with no input.
    repeat (3) begin
      @(negedge clk);
      check("rst_hold", {pair_valid, busy, dout_R_1, dout_Q_1, dout_R_2, dout_Q_2}, 0);
    end
    rstn = 1'b1;
    for (int i = 0; i < 10; i++) begin
      idle(1);
      check("rst_idle", {busy, pair_valid}, 0);
    end
    drain("rst_idle", 0);

    frame(0, 0, -1, 1'b0);
    idle(2);
    drain("gapless", 4);

    frame(32, 3, -1, 1'b0);
    idle(2);
    drain("gapped", 4);

    frame(64, 0, -1, 1'b0);
    frame(96, 0, -1, 1'b0);
    frame(128, 0, -1, 1'b0);
    idle(2);
    gap12 = (pq.size() >= 5) ? pq[4].cyc - pq[0].cyc : -1;
    check("b2b_gap", gap12, 8);
    drain("b2b", 12);

    // Flush during PAIR drops the flushed beat; pairs for b=4,5 already went out.
    frame(160, 0, 6, 1'b0);
    frame(192, 0, -1, 1'b0);
    idle(2);
    drain("flush6", 6);

    frame(224, 0, 2, 1'b0);
    frame(256, 0, -1, 1'b0);
    idle(2);
    drain("flush2", 4);

    // Async reset at beat 5: pair for beat 4 was emitted, rest of the frame discarded.
    frame(288, 0, 5, 1'b1);
    idle(2);
    rstn = 1'b1;
    frame(320, 0, -1, 1'b0);
    idle(2);
    drain("rst_mid", 5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/bf2_pair_feeder.md
# bf2_pair_feeder

Input-side partner of the radix-2 butterfly stage (BF2I bundle) in the FFT datapath. Accepts a continuous or gapped stream of DEPTH-lane complex sample bundles and buffers the first half of each frame. As the second half arrives, it presents matched pairs (x[k], x[k+HALF]) with a qualifying enable. Its outputs drive the butterfly's din_*_1 / din_*_2 / en inputs directly.

## Interface
- WIDTH, 13: signed sample width, I and Q.
- DEPTH, 2: lanes per bundle, one beat per cycle.
- HALF, 4: beats per half-frame; pair distance in beats; must be ≥2.

- clk  in  1  clock, rising edge.
- rstn  in  1  reset, asynchronous, active-low.
- flush  in  1  synchronous clear of the frame state.
- in_valid  in  1  input beat qualifier.
- din_R  in  DEPTH×WIDTH signed  real lanes.
- din_Q  in  DEPTH×WIDTH signed  imaginary lanes.
- pair_valid  out  1  pair qualifier; drives the butterfly en.
- dout_R_1, dout_Q_1  out  DEPTH×WIDTH signed  first-half sample (buffered).
- dout_R_2, dout_Q_2  out  DEPTH×WIDTH signed  second-half sample (live).
- busy  out  1  high while in PAIR state.

## Operation
- Beat counter cnt, 0..HALF-1, advances only on accepted beats (in_valid=1, flush=0).
- States:
  - FILL (reset state). On each accepted beat, write din_R/din_Q into buffer entry cnt. On the beat with cnt=HALF-1, set cnt←0 and go to PAIR.
  - PAIR. On each accepted beat:
    - Register buffer[cnt] onto dout_*_1 and din onto dout_*_2, and set pair_valid=1.
    - On the beat with cnt=HALF-1, set cnt←0 and go to FILL.
- Buffer: HALF × DEPTH × 2 × WIDTH bits. Written only in FILL, read only in PAIR. No bypass is needed, because a read never targets an entry being written in the same cycle.
- Any cycle with no accepted PAIR beat: pair_valid=0 and all dout_* = 0.
- in_valid gaps: cnt and state hold, buffer contents are preserved, and no pair is emitted.
- No arithmetic: data is passed bit-exact with no width change. Sign handling is left to the butterfly.
- flush=1: next cycle state=FILL, cnt=0, pair_valid=0, dout_*=0. Buffer contents are not cleared; they are stale and are overwritten by the next FILL. flush has priority over a same-cycle in_valid, and that beat is dropped.
- rstn asserted mid-frame: the partial frame is discarded. After release, the first accepted beat is beat 0 of a new frame.

## Timing
- Reset values: pair_valid=0, busy=0, all dout_*=0, state=FILL, cnt=0. Buffer contents are undefined.
- Latency: the second-half beat accepted at edge n appears on dout_* with pair_valid=1 after edge n (registered, 1 cycle).
- Throughput: one beat per cycle.
  - A gapless stream yields HALF idle output cycles followed by HALF consecutive pair_valid cycles per frame.
  - Combined with the butterfly's 1-cycle register, the first butterfly result follows beat HALF by 2 cycles.
- busy is registered: high the cycle after the FILL→PAIR transition, low the cycle after the PAIR→FILL transition.
- Back-to-back frames: the FILL of frame m+1 starts on the cycle after the last PAIR beat of frame m, with no bubble.

## Configuration
- Macro BF2_FEEDER_FRAME_TAG_EN.
- Defined: adds two outputs.
  - pair_idx [$clog2(HALF)-1:0] carries the cnt value of the emitted pair.
  - frame_last is high with the pair_valid for index HALF-1.
  - Both reset to 0 and are 0 whenever pair_valid=0.
- Undefined: neither port exists. Behaviour is otherwise identical.

## Test plan
- Reset and idle: hold rstn low, then release with in_valid=0 for 10 cycles. Every cycle must show pair_valid=0, dout_*=0, busy=0.
- Gapless frame (DEPTH=2, HALF=4): drive beats b with din_R={b, -b} and din_Q={100+b, -100-b}, b=0..7.
  - pair_valid is high for 4 cycles, starting 1 cycle after b=4.
  - Pair k shows dout_R_1={k,-k} and dout_R_2={k+4,-(k+4)}, with matching Q lanes.
- Gapped input: the same frame with in_valid low for 3 cycles after b=2 and after b=5. Pair values are unchanged, and no pair_valid appears in the gap cycles.
- Back-to-back frames: 3 frames × 8 beats, gapless, with distinct values per frame.
  - Exactly 12 pair_valid cycles.
  - Pairs never mix frames.
  - The first pair of frame 2 occurs 8 cycles after the first pair of frame 1.
- Flush: flush with in_valid=1 at b=6, then restart a frame at b=0.
  - No pair for the dropped beat.
  - The new frame pairs correctly and shows no stale values.
  - Repeat with flush at b=2, mid-FILL.
- Async reset mid-PAIR: assert rstn at b=5.
  - Outputs go to 0 immediately.
  - After release, a fresh 8-beat frame produces correct pairs.
  - With BF2_FEEDER_FRAME_TAG_EN defined, pair_idx runs 0,1,2,3 and frame_last is high only on index 3.
